// File: rtl/unified_sram_arbiter.sv
// unified_sram_arbiter
// Shares one synchronous single-port SRAM between the CPU instruction-fetch
// requester (i_*) and the data load/store requester (d_*). At most one access
// is granted per cycle. Each read response goes back to its owner exactly
// LATENCY cycles after the grant. A saturating counter records collisions.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   i_req/i_addr    instruction read request, held until i_gnt
//   i_gnt           instruction request accepted this cycle (combinational)
//   i_rvalid/i_rdata instruction read response
//   d_req/d_wen/d_addr/d_wdata  data request (d_wen == 0 means read)
//   d_gnt           data request accepted this cycle (combinational)
//   d_rvalid/d_rdata data read response
//   d_wack          data write completed
//   mem_en/mem_wen/mem_addr/mem_wdata  SRAM command port
//   mem_rdata       SRAM read data, valid LATENCY cycles after issue
//   conflict_cnt    cycles with both requests high, saturating at 16'hFFFF
module unified_sram_arbiter #(
    parameter int LATENCY = 1,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [AW-1:0]     i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DW-1:0]     i_rdata,
    input  logic              d_req,
    input  logic [DW/8-1:0]   d_wen,
    input  logic [AW-1:0]     d_addr,
    input  logic [DW-1:0]     d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic              d_wack,
    output logic [DW-1:0]     d_rdata,
    output logic              mem_en,
    output logic [DW/8-1:0]   mem_wen,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata,
    output logic [15:0]       conflict_cnt
);

    localparam int BW = DW / 8;

    typedef enum logic [1:0] {
        TAG_NONE   = 2'd0,
        TAG_IREAD  = 2'd1,
        TAG_DREAD  = 2'd2,
        TAG_DWRITE = 2'd3
    } tag_e;

    typedef enum logic {
        WIN_INST = 1'b0,
        WIN_DATA = 1'b1
    } win_e;

    tag_e        tag_r [LATENCY];
    win_e        last_win_r;
    logic [15:0] conflict_cnt_r;

    logic        i_gnt_s;
    logic        d_gnt_s;
    logic        collide_s;
    tag_e        issue_tag_s;

    // Arbitration: a single requester wins outright; on a collision the side
    // that lost the previous collision wins. Everything is masked in reset.
    always_comb begin
        i_gnt_s   = 1'b0;
        d_gnt_s   = 1'b0;
        collide_s = 1'b0;
        if (rst) begin
            i_gnt_s   = 1'b0;
            d_gnt_s   = 1'b0;
            collide_s = 1'b0;
        end else if (i_req && d_req) begin
            collide_s = 1'b1;
            if (last_win_r == WIN_INST) begin
                d_gnt_s = 1'b1;
            end else begin
                i_gnt_s = 1'b1;
            end
        end else if (i_req) begin
            i_gnt_s = 1'b1;
        end else if (d_req) begin
            d_gnt_s = 1'b1;
        end else begin
            i_gnt_s = 1'b0;
            d_gnt_s = 1'b0;
        end
    end

    // SRAM command mux and the tag for the access issued this cycle.
    always_comb begin
        mem_en      = 1'b0;
        mem_wen     = {BW{1'b0}};
        mem_addr    = {AW{1'b0}};
        mem_wdata   = {DW{1'b0}};
        issue_tag_s = TAG_NONE;
        if (i_gnt_s) begin
            mem_en      = 1'b1;
            mem_addr    = i_addr;
            issue_tag_s = TAG_IREAD;
        end else if (d_gnt_s) begin
            mem_en      = 1'b1;
            mem_wen     = d_wen;
            mem_addr    = d_addr;
            mem_wdata   = d_wdata;
            issue_tag_s = (d_wen == {BW{1'b0}}) ? TAG_DREAD : TAG_DWRITE;
        end else begin
            mem_en      = 1'b0;
            issue_tag_s = TAG_NONE;
        end
    end

    // Tag shift register, collision winner memory and saturating counter.
    // Reset flushes every in-flight tag so no stale response can emerge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LATENCY; k++) begin
                tag_r[k] <= TAG_NONE;
            end
            last_win_r     <= WIN_INST;
            conflict_cnt_r <= 16'd0;
        end else begin
            tag_r[0] <= issue_tag_s;
            for (int k = 1; k < LATENCY; k++) begin
                tag_r[k] <= tag_r[k-1];
            end
            if (collide_s) begin
                last_win_r <= d_gnt_s ? WIN_DATA : WIN_INST;
                if (conflict_cnt_r != 16'hFFFF) begin
                    conflict_cnt_r <= conflict_cnt_r + 16'd1;
                end else begin
                    conflict_cnt_r <= conflict_cnt_r;
                end
            end else begin
                last_win_r     <= last_win_r;
                conflict_cnt_r <= conflict_cnt_r;
            end
        end
    end

    // The pipeline tail lines up with the cycle in which mem_rdata is valid
    // for that access, so responses decode straight from the tail register.
    assign i_gnt        = i_gnt_s;
    assign d_gnt        = d_gnt_s;
    assign i_rvalid     = (tag_r[LATENCY-1] == TAG_IREAD);
    assign d_rvalid     = (tag_r[LATENCY-1] == TAG_DREAD);
    assign d_wack       = (tag_r[LATENCY-1] == TAG_DWRITE);
    assign i_rdata      = i_rvalid ? mem_rdata : {DW{1'b0}};
    assign d_rdata      = d_rvalid ? mem_rdata : {DW{1'b0}};
    assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_unified_sram_arbiter.sv
// Directed bench for unified_sram_arbiter. Three instances (LATENCY 1, 2, 3)
// share one stimulus; each scenario checks the instance whose latency it
// targets. Inputs change 1 time unit after the rising edge and outputs are
// sampled 2 units later, well before the next edge.
module tb_unified_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic        d_req;
    logic [31:0] i_addr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] mem_rdata;
    logic [3:0]  d_wen;

    logic [2:0]  i_gnt_a;
    logic [2:0]  d_gnt_a;
    logic [2:0]  i_rvalid_a;
    logic [2:0]  d_rvalid_a;
    logic [2:0]  d_wack_a;
    logic [2:0]  mem_en_a;
    logic [31:0] i_rdata_a   [3];
    logic [31:0] d_rdata_a   [3];
    logic [31:0] mem_addr_a  [3];
    logic [31:0] mem_wdata_a [3];
    logic [3:0]  mem_wen_a   [3];
    logic [15:0] cnt_a       [3];

    int checks_cnt = 0;
    int errors_cnt = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        unified_sram_arbiter #(
            .LATENCY(g + 1),
            .AW     (32),
            .DW     (32)
        ) u_dut (
            .clk         (clk),
            .rst         (rst),
            .i_req       (i_req),
            .i_addr      (i_addr),
            .i_gnt       (i_gnt_a[g]),
            .i_rvalid    (i_rvalid_a[g]),
            .i_rdata     (i_rdata_a[g]),
            .d_req       (d_req),
            .d_wen       (d_wen),
            .d_addr      (d_addr),
            .d_wdata     (d_wdata),
            .d_gnt       (d_gnt_a[g]),
            .d_rvalid    (d_rvalid_a[g]),
            .d_wack      (d_wack_a[g]),
            .d_rdata     (d_rdata_a[g]),
            .mem_en      (mem_en_a[g]),
            .mem_wen     (mem_wen_a[g]),
            .mem_addr    (mem_addr_a[g]),
            .mem_wdata   (mem_wdata_a[g]),
            .mem_rdata   (mem_rdata),
            .conflict_cnt(cnt_a[g])
        );
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        i_req = 1'b1;
        d_req = 1'b1;
        cyc();
        #2;
        check_eq("rst_i_gnt", {61'd0, i_gnt_a}, 64'd0);
        check_eq("rst_d_gnt", {61'd0, d_gnt_a}, 64'd0);
        check_eq("rst_mem_en", {61'd0, mem_en_a}, 64'd0);
        cyc();
        #2;
        check_eq("rst_rvalid", {58'd0, i_rvalid_a, d_rvalid_a}, 64'd0);
        check_eq("rst_wack", {61'd0, d_wack_a}, 64'd0);
        check_eq("rst_cnt", {48'd0, cnt_a[0]}, 64'd0);
        rst   = 1'b0;
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        i_req     = 1'b0;
        d_req     = 1'b0;
        i_addr    = 32'd0;
        d_addr    = 32'd0;
        d_wdata   = 32'd0;
        d_wen     = 4'h0;
        mem_rdata = 32'd0;

        // Scenario 1: lone instruction fetch, LATENCY=1
        do_reset();
        cyc();
        i_req  = 1'b1;
        i_addr = 32'hBFC0_0000;
        #2;
        check_eq("s1_i_gnt", {63'd0, i_gnt_a[0]}, 64'd1);
        check_eq("s1_d_gnt", {63'd0, d_gnt_a[0]}, 64'd0);
        check_eq("s1_mem_en", {63'd0, mem_en_a[0]}, 64'd1);
        check_eq("s1_mem_wen", {60'd0, mem_wen_a[0]}, 64'd0);
        check_eq("s1_mem_addr", {32'd0, mem_addr_a[0]}, 64'hBFC0_0000);
        cyc();
        i_req     = 1'b0;
        mem_rdata = 32'h3C01_0001;
        #2;
        check_eq("s1_i_rvalid", {63'd0, i_rvalid_a[0]}, 64'd1);
        check_eq("s1_i_rdata", {32'd0, i_rdata_a[0]}, 64'h3C01_0001);
        check_eq("s1_d_rvalid", {63'd0, d_rvalid_a[0]}, 64'd0);
        check_eq("s1_idle_mem_en", {63'd0, mem_en_a[0]}, 64'd0);

        // Scenario 2: collisions alternate winners, first goes to DATA
        do_reset();
        cyc();
        i_req  = 1'b1;
        d_req  = 1'b1;
        d_wen  = 4'h0;
        i_addr = 32'h0000_0040;
        d_addr = 32'h0000_0200;
        #2;
        check_eq("s2_c1_d_gnt", {63'd0, d_gnt_a[0]}, 64'd1);
        check_eq("s2_c1_i_gnt", {63'd0, i_gnt_a[0]}, 64'd0);
        check_eq("s2_c1_mem_addr", {32'd0, mem_addr_a[0]}, 64'h200);
        cyc();
        mem_rdata = 32'h1111_1111;
        #2;
        check_eq("s2_c2_i_gnt", {63'd0, i_gnt_a[0]}, 64'd1);
        check_eq("s2_c2_d_gnt", {63'd0, d_gnt_a[0]}, 64'd0);
        check_eq("s2_c2_cnt", {48'd0, cnt_a[0]}, 64'd1);
        check_eq("s2_c2_mem_addr", {32'd0, mem_addr_a[0]}, 64'h40);
        check_eq("s2_c2_d_rvalid", {63'd0, d_rvalid_a[0]}, 64'd1);
        check_eq("s2_c2_d_rdata", {32'd0, d_rdata_a[0]}, 64'h1111_1111);
        check_eq("s2_c2_i_rdata", {32'd0, i_rdata_a[0]}, 64'd0);
        cyc();
        #2;
        check_eq("s2_c3_d_gnt", {63'd0, d_gnt_a[0]}, 64'd1);
        check_eq("s2_c3_cnt", {48'd0, cnt_a[0]}, 64'd2);
        check_eq("s2_c3_i_rvalid", {63'd0, i_rvalid_a[0]}, 64'd1);
        check_eq("s2_c3_i_rdata", {32'd0, i_rdata_a[0]}, 64'h1111_1111);
        cyc();
        i_req = 1'b0;
        d_req = 1'b0;
        #2;
        check_eq("s2_end_cnt", {48'd0, cnt_a[0]}, 64'd3);
        check_eq("s2_end_mem_addr", {32'd0, mem_addr_a[0]}, 64'd0);

        // Scenario 3: data write, LATENCY=2
        do_reset();
        cyc();
        d_req   = 1'b1;
        d_wen   = 4'hF;
        d_addr  = 32'h0000_0100;
        d_wdata = 32'hDEAD_BEEF;
        #2;
        check_eq("s3_d_gnt", {63'd0, d_gnt_a[1]}, 64'd1);
        check_eq("s3_mem_wen", {60'd0, mem_wen_a[1]}, 64'hF);
        check_eq("s3_mem_wdata", {32'd0, mem_wdata_a[1]}, 64'hDEAD_BEEF);
        check_eq("s3_mem_addr", {32'd0, mem_addr_a[1]}, 64'h100);
        cyc();
        d_req = 1'b0;
        d_wen = 4'h0;
        #2;
        check_eq("s3_wack_early", {63'd0, d_wack_a[1]}, 64'd0);
        check_eq("s3_mem_wdata_idle", {32'd0, mem_wdata_a[1]}, 64'd0);
        cyc();
        #2;
        check_eq("s3_wack", {63'd0, d_wack_a[1]}, 64'd1);
        check_eq("s3_d_rvalid", {63'd0, d_rvalid_a[1]}, 64'd0);
        cyc();
        #2;
        check_eq("s3_wack_late", {63'd0, d_wack_a[1]}, 64'd0);

        // Scenario 4: IREAD, DREAD, IREAD back to back, LATENCY=3
        do_reset();
        cyc();
        i_req = 1'b1;
        cyc();
        i_req = 1'b0;
        d_req = 1'b1;
        d_wen = 4'h0;
        cyc();
        d_req = 1'b1;
        d_req = 1'b0;
        i_req = 1'b1;
        #2;
        check_eq("s4_c2_none", {62'd0, i_rvalid_a[2], d_rvalid_a[2]}, 64'd0);
        cyc();
        i_req     = 1'b0;
        mem_rdata = 32'hA1A1_A1A1;
        #2;
        check_eq("s4_c3_i_rvalid", {63'd0, i_rvalid_a[2]}, 64'd1);
        check_eq("s4_c3_i_rdata", {32'd0, i_rdata_a[2]}, 64'hA1A1_A1A1);
        check_eq("s4_c3_d_rvalid", {63'd0, d_rvalid_a[2]}, 64'd0);
        cyc();
        mem_rdata = 32'hB2B2_B2B2;
        #2;
        check_eq("s4_c4_d_rvalid", {63'd0, d_rvalid_a[2]}, 64'd1);
        check_eq("s4_c4_d_rdata", {32'd0, d_rdata_a[2]}, 64'hB2B2_B2B2);
        check_eq("s4_c4_i_rvalid", {63'd0, i_rvalid_a[2]}, 64'd0);
        cyc();
        mem_rdata = 32'hC3C3_C3C3;
        #2;
        check_eq("s4_c5_i_rvalid", {63'd0, i_rvalid_a[2]}, 64'd1);
        check_eq("s4_c5_i_rdata", {32'd0, i_rdata_a[2]}, 64'hC3C3_C3C3);
        cyc();
        #2;
        check_eq("s4_c6_none", {62'd0, i_rvalid_a[2], d_rvalid_a[2]}, 64'd0);

        // Scenario 5: reset with two reads in flight, LATENCY=2
        do_reset();
        cyc();
        i_req = 1'b1;
        d_req = 1'b1;
        d_wen = 4'h0;
        #2;
        check_eq("s5_c0_d_gnt", {63'd0, d_gnt_a[1]}, 64'd1);
        cyc();
        d_req = 1'b0;
        #2;
        check_eq("s5_c1_i_gnt", {63'd0, i_gnt_a[1]}, 64'd1);
        check_eq("s5_c1_cnt", {48'd0, cnt_a[1]}, 64'd1);
        cyc();
        i_req = 1'b0;
        rst   = 1'b1;
        cyc();
        rst   = 1'b0;
        i_req = 1'b1;
        d_req = 1'b1;
        #2;
        check_eq("s5_c3_rvalid", {62'd0, i_rvalid_a[1], d_rvalid_a[1]}, 64'd0);
        check_eq("s5_c3_cnt", {48'd0, cnt_a[1]}, 64'd0);
        check_eq("s5_c3_d_gnt", {63'd0, d_gnt_a[1]}, 64'd1);
        cyc();
        i_req = 1'b0;
        d_req = 1'b0;
        #2;
        check_eq("s5_c4_rvalid", {62'd0, i_rvalid_a[1], d_rvalid_a[1]}, 64'd0);
        check_eq("s5_c4_cnt", {48'd0, cnt_a[1]}, 64'd1);

        // Scenario 6: counter saturation
        do_reset();
        cyc();
        i_req = 1'b1;
        d_req = 1'b1;
        repeat (65534) cyc();
        #2;
        check_eq("s6_cnt_fffe", {48'd0, cnt_a[0]}, 64'hFFFE);
        for (int n = 0; n < 3; n++) begin
            cyc();
            #2;
            check_eq("s6_cnt_sat", {48'd0, cnt_a[0]}, 64'hFFFF);
        end
        cyc();
        i_req = 1'b0;
        d_req = 1'b0;
        #2;
        check_eq("s6_cnt_hold", {48'd0, cnt_a[0]}, 64'hFFFF);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule

// File: doc/unified_sram_arbiter.md
Name: unified_sram_arbiter

Overview:
- Shares one synchronous single-port SRAM between the multicycle CPU's instruction-fetch requester and its data load/store requester.
- Grants at most one access per cycle, drives the SRAM port, and routes each read response back to its owner after a fixed SRAM latency.
- Round-robin arbitration when both requesters collide; a saturating counter records collisions.
- Sits between mycpu_top's inst_sram_*/data_sram_* ports and a single SRAM macro.

Parameters:
- LATENCY, 1, SRAM read latency in cycles from the issue cycle to valid mem_rdata (legal 1..4).
- AW, 32, address width.
- DW, 32, data width; byte-enable width is DW/8.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- i_req  in  1  instruction read request; held with i_addr until i_gnt
- i_addr  in  AW  instruction address
- i_gnt  out  1  request accepted this cycle (combinational)
- i_rvalid  out  1  instruction read data valid
- i_rdata  out  DW  instruction read data
- d_req  in  1  data request; held with d_addr/d_wen/d_wdata until d_gnt
- d_wen  in  DW/8  byte write enables; all zero = read
- d_addr  in  AW  data address
- d_wdata  in  DW  data write data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  data read data valid
- d_wack  out  1  data write completed
- d_rdata  out  DW  data read data
- mem_en  out  1  SRAM enable
- mem_wen  out  DW/8  SRAM byte write enables
- mem_addr  out  AW  SRAM address
- mem_wdata  out  DW  SRAM write data
- mem_rdata  in  DW  SRAM read data, valid LATENCY cycles after the issue cycle
- conflict_cnt  out  16  number of cycles with i_req and d_req both high; saturates at 16'hFFFF

Behaviour:
- Arbitration (combinational, same cycle):
  - Only one requester high: grant it.
  - Both high: grant the requester that did not win the last collision.
  - Winner register last_win resets to INST, so the first collision goes to DATA.
  - last_win updates only on collision cycles; non-collision grants leave it unchanged.
- SRAM port:
  - mem_en = i_gnt | d_gnt.
  - On an instruction grant: mem_addr = i_addr, mem_wen = 0, mem_wdata = 0.
  - On a data grant: mem_addr = d_addr, mem_wen = d_wen, mem_wdata = d_wdata.
  - No grant: all mem_* outputs are 0.
- Tag pipeline:
  - LATENCY-deep shift register of 2-bit tags {NONE, IREAD, DREAD, DWRITE}.
  - Stage 0 is loaded with the granted access type each cycle; NONE when nothing is granted.
  - Grants may issue every cycle; up to LATENCY accesses can be outstanding.
  - Responses return strictly in issue order.
- Responses, driven from the pipeline tail (registered):
  - Tail IREAD: i_rvalid = 1.
  - Tail DREAD: d_rvalid = 1.
  - Tail DWRITE: d_wack = 1.
  - i_rdata and d_rdata are mem_rdata when the matching valid is high, else 0.
  - Each response appears exactly LATENCY cycles after its grant cycle.
- The arbiter never back-pressures responses and never reorders them.
- Reset:
  - Registered outputs clear to 0: i_rvalid, d_rvalid, d_wack, conflict_cnt.
  - All tags clear to NONE; last_win returns to INST.
  - Combinational outputs (gnt, mem_*) are forced to 0 while rst = 1.
  - Reset mid-operation discards every in-flight response; no valid/wack pulses occur after reset for accesses issued before it.
- Boundary cases:
  - conflict_cnt holds at 16'hFFFF once saturated.
  - A requester dropping req before being granted is legal; no grant and no response result.
  - A back-to-back collision on consecutive cycles alternates winners.

Test Plan:
- Reset, LATENCY=1, only i_req with i_addr=0xBFC00000, mem_rdata=0x3C010001 next cycle: i_gnt=1 in cycle 0; mem_en=1, mem_wen=0, mem_addr=0xBFC00000; i_rvalid=1 with i_rdata=0x3C010001 in cycle 1; d_rvalid=0.
- Simultaneous i_req and d_req read right after reset: d_gnt first; i_gnt the next cycle with both held; conflict_cnt=1 after the first cycle. Second collision cycle grants INST, third grants DATA (alternation).
- Data write d_wen=4'hF, d_addr=0x100, d_wdata=0xDEADBEEF, LATENCY=2: mem_wen=4'hF and mem_wdata=0xDEADBEEF in the grant cycle; d_wack pulses exactly 2 cycles later; d_rvalid stays 0.
- LATENCY=3, grants on consecutive cycles IREAD, DREAD, IREAD: i_rvalid, d_rvalid, i_rvalid on cycles 3, 4, 5 with the corresponding mem_rdata values.
- Assert rst with two reads outstanding (LATENCY=2): no rvalid pulses afterward; conflict_cnt=0; the next collision goes to DATA.
- Force conflict_cnt to 16'hFFFE, then 3 collision cycles: reads 16'hFFFF and holds.
